// File: rtl/data_mem_responder.sv
// Multi-cycle RV32I data-memory slave: one load/store per request, fixed latency,
// byte/half/word little-endian access, faults on misalignment/illegal size/conflict.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        done,
   output logic        err
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned ADR_W = IDX_W + 2;
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]       state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             req, accept, commit;

   logic [ADR_W-1:0] addr_q;
   logic [31:0]      wdata_q;
   logic [2:0]       funct3_q;
   logic             is_write_q, conflict_q;

   logic [31:0]      mem [DEPTH_WORDS];
   logic [IDX_W-1:0] idx;
   logic [31:0]      word;
   logic [1:0]       size, lane;
   logic             legal, misal, fault;
   logic [7:0]       byte_v;
   logic [15:0]      half_v;
   logic [31:0]      ld_val, st_data;
   logic [3:0]       st_be;
   logic             we;

   // Address bits above the array index are intentionally ignored (wrap-around).
   logic unused_addr;
   assign unused_addr = ^addr[31:ADR_W];

   assign req   = MemRead | MemWrite;
   assign stall = ((state == S_IDLE) && req) || (state == S_WAIT);

   // State and latency counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // Next-state logic: accept in IDLE, count down in WAIT, one cycle of RESP.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      accept  = 1'b0;
      commit  = 1'b0;
      case (state)
         S_IDLE: begin
            if (req) begin
               state_d = S_WAIT;
               cnt_d   = CNT_W'(LATENCY - 1);
               accept  = 1'b1;
            end
         end
         S_WAIT: begin
            if (cnt != '0) begin
               cnt_d = cnt - CNT_W'(1);
            end else begin
               state_d = S_RESP;
               commit  = 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request capture; everything downstream works from these copies.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         funct3_q   <= '0;
         is_write_q <= 1'b0;
         conflict_q <= 1'b0;
      end else if (accept) begin
         addr_q     <= addr[ADR_W-1:0];
         wdata_q    <= wdata;
         funct3_q   <= funct3;
         is_write_q <= MemWrite;
         conflict_q <= MemRead & MemWrite;
      end
   end

   assign idx  = addr_q[ADR_W-1:2];
   assign lane = addr_q[1:0];
   assign size = funct3_q[1:0];
   assign word = mem[idx];

   // Fault decode: legal funct3 per direction, natural alignment, conflict.
   always_comb begin
      legal = 1'b0;
      if (is_write_q) begin
         case (funct3_q)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            default:                legal = 1'b0;
         endcase
      end else begin
         case (funct3_q)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
            default:                                legal = 1'b0;
         endcase
      end
      misal = ((size == 2'b01) && addr_q[0]) || ((size == 2'b10) && (lane != 2'b00));
      fault = conflict_q | ~legal | misal;
   end

   // Load lane select with sign/zero extension.
   always_comb begin
      byte_v = word[{lane, 3'b000} +: 8];
      half_v = addr_q[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   ld_val = funct3_q[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
         2'b01:   ld_val = funct3_q[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
         default: ld_val = word;
      endcase
   end

   // Store lane replication and byte enables.
   always_comb begin
      case (size)
         2'b00: begin
            st_data = {4{wdata_q[7:0]}};
            st_be   = 4'b0001 << lane;
         end
         2'b01: begin
            st_data = {2{wdata_q[15:0]}};
            st_be   = addr_q[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            st_data = wdata_q;
            st_be   = 4'b1111;
         end
      endcase
   end

   assign we = commit & is_write_q & ~fault;

   // Storage array, byte-lane writes, not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (st_be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
         end
      end
   end

   // Registered response: done/err pulse in RESP, rdata updated by loads or faults.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         done <= commit;
         err  <= commit & fault;
         if (commit) begin
            if (fault)            rdata <= '0;
            else if (!is_write_q) rdata <= ld_val;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: driver pushes expected responses,
// a negedge monitor pops and compares on every done pulse.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [2:0]  funct3 = '0;
   logic [31:0] rdata;
   logic        stall, done, err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] q_rdata[$];
   logic        q_err[$];
   logic [31:0] last_rdata = '0;

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
      .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
      .addr(addr), .wdata(wdata), .funct3(funct3),
      .rdata(rdata), .stall(stall), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected response.
   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            if (q_rdata.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: got done=1 expected none (rdata=0x%08h)", rdata);
            end else begin
               check("resp_rdata", rdata, q_rdata.pop_front());
               check("resp_err", 32'(err), 32'(q_err.pop_front()));
            end
         end else if (err) begin
            check("err_without_done", 32'(err), 32'd0);
         end
      end
   end

   task automatic set_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3);
      MemRead = rd; MemWrite = wr; addr = a; wdata = wd; funct3 = f3;
   endtask

   task automatic expect_resp(input logic [31:0] exp_rdata, input logic exp_err);
      q_rdata.push_back(exp_rdata);
      q_err.push_back(exp_err);
      last_rdata = exp_rdata;
   endtask

   // Wait (bounded) for done, counting stall cycles up to it.
   task automatic wait_done(output int stalls);
      bit seen = 0;
      stalls = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            check("stall_low_in_resp", 32'(stall), 32'd0);
            break;
         end
         if (stall) stalls++;
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: got no done in 20 cycles expected done");
      end
   endtask

   // One full access: issue, wait for completion, release in the cycle after RESP.
   task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f3,
                         input logic [31:0] exp_rdata, input logic exp_err);
      int stalls;
      expect_resp(exp_rdata, exp_err);
      @(posedge clk); #1;
      set_req(rd, wr, a, wd, f3);
      wait_done(stalls);
      check("stall_cycles", 32'(stalls), 32'd3);
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
   endtask

   task automatic load(input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] exp_rdata, input logic exp_err);
      access(1'b1, 1'b0, a, 32'h0, f3, exp_rdata, exp_err);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                        input logic exp_err);
      access(1'b0, 1'b1, a, wd, f3, exp_err ? 32'h0 : last_rdata, exp_err);
   endtask

   initial begin
      int stalls;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rdata", rdata, 32'h0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_err", 32'(err), 32'd0);
      check("reset_stall", 32'(stall), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Word store/load and sub-word loads with extension.
      store(32'h10, 32'hDEADBEEF, 3'b010, 1'b0);
      load (32'h10, 3'b010, 32'hDEADBEEF, 1'b0);
      load (32'h13, 3'b000, 32'hFFFFFFDE, 1'b0);
      load (32'h13, 3'b100, 32'h000000DE, 1'b0);
      load (32'h10, 3'b001, 32'hFFFFBEEF, 1'b0);
      load (32'h12, 3'b101, 32'h0000DEAD, 1'b0);
      load (32'h11, 3'b100, 32'h000000BE, 1'b0);

      // Partial stores only touch their lanes; stores leave rdata unchanged.
      store(32'h11, 32'h000000AA, 3'b000, 1'b0);
      load (32'h10, 3'b010, 32'hDEADAAEF, 1'b0);
      store(32'h12, 32'h00001234, 3'b001, 1'b0);
      load (32'h10, 3'b010, 32'h1234AAEF, 1'b0);

      // Faults.
      load (32'h12, 3'b010, 32'h0, 1'b1);
      store(32'h20, 32'hCAFEF00D, 3'b010, 1'b0);
      store(32'h21, 32'h0000FFFF, 3'b001, 1'b1);
      load (32'h20, 3'b010, 32'hCAFEF00D, 1'b0);
      load (32'h20, 3'b011, 32'h0, 1'b1);
      load (32'h20, 3'b010, 32'hCAFEF00D, 1'b0);
      store(32'h20, 32'h0, 3'b100, 1'b1);
      load (32'h20, 3'b010, 32'hCAFEF00D, 1'b0);
      access(1'b1, 1'b1, 32'h20, 32'h0, 3'b010, 32'h0, 1'b1);
      load (32'h20, 3'b010, 32'hCAFEF00D, 1'b0);

      // Wrap-around modulo 256 words.
      store(32'h400, 32'h00000055, 3'b010, 1'b0);
      load (32'h0, 3'b010, 32'h00000055, 1'b0);

      // Reset during WAIT: no commit, outputs cleared at once.
      store(32'h30, 32'h11111111, 3'b010, 1'b0);
      load (32'h30, 3'b010, 32'h11111111, 1'b0);
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 32'h30, 32'h22222222, 3'b010);
      @(posedge clk); #1;
      check("wait_stall", 32'(stall), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      set_req(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      #1;
      check("midrst_rdata", rdata, 32'h0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_err", 32'(err), 32'd0);
      check("midrst_stall", 32'(stall), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      last_rdata = 32'h0;
      load (32'h30, 3'b010, 32'h11111111, 1'b0);

      // Request held through RESP is accepted exactly once more.
      expect_resp(32'h0000AAEF, 1'b0);
      expect_resp(32'h0000AAEF, 1'b0);
      @(posedge clk); #1;
      set_req(1'b1, 1'b0, 32'h10, 32'h0, 3'b101);
      wait_done(stalls);
      check("held_first_stalls", 32'(stalls), 32'd3);
      @(negedge clk);
      check("held_idle_stall", 32'(stall), 32'd1);
      check("held_idle_done", 32'(done), 32'd0);
      wait_done(stalls);
      check("held_second_stalls", 32'(stalls), 32'd2);
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);

      repeat (8) @(negedge clk);
      check("queue_drained", 32'(q_rdata.size()), 32'd0);
      check("idle_stall", 32'(stall), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
